fp_add_scheduler: RTL

FP_ADD_SCHEDULER -- requirements
Module: fp_add_scheduler

---
 rtl/fp_add_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fp_add_scheduler.sv
// rtl/fp_add_scheduler.sv - round-robin scheduler sharing one FP adder among NREQ requesters
// One operation in flight: accept in IDLE, wait ADD_LAT edges, hold result in RESP until taken.
module fp_add_scheduler #(
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 1,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_sub,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  input  logic [31:0]          add_result,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic [IDW-1:0]       resp_id,
  output logic                 busy,
  output logic [15:0]          op_count
);

  localparam int CW = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [IDW-1:0]  r_rr_ptr;
  logic [CW-1:0]   r_wait_cnt;
  logic [31:0]     r_add_a;
  logic [31:0]     r_add_b;
  logic [31:0]     r_resp_data;
  logic [IDW-1:0]  r_resp_id;
  logic            r_resp_valid;
  logic [15:0]     r_op_count;

  logic [IDW-1:0]  w_grant;
  logic            w_grant_valid;
  logic            w_accept;
  logic            w_lat_done;
  logic [31:0]     w_a [NREQ];
  logic [31:0]     w_b [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_a[i] = req_a[i*32 +: 32];
      w_b[i] = req_b[i*32 +: 32];
    end
  end

  // Scan downward from the farthest slot so the first valid at or after rr_ptr wins.
  always_comb begin
    int w_idx;
    w_grant       = '0;
    w_grant_valid = 1'b0;
    w_idx         = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (req_valid[w_idx]) begin
        w_grant       = IDW'(w_idx);
        w_grant_valid = 1'b1;
      end
    end
  end

  assign w_accept   = (r_state == S_IDLE) && w_grant_valid;
  assign w_lat_done = (r_wait_cnt == CW'(ADD_LAT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_state_next = S_WAIT;
      S_WAIT:  if (w_lat_done) w_state_next = S_RESP;
      S_RESP:  if (resp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // reset_n gate keeps req_ready low while reset is held, even with requests pending.
  always_comb begin
    busy      = (r_state != S_IDLE);
    req_ready = '0;
    if (reset_n && w_accept) req_ready = NREQ'(1) << w_grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr     <= '0;
      r_wait_cnt   <= '0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_resp_data  <= '0;
      r_resp_id    <= '0;
      r_resp_valid <= 1'b0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_add_a    <= w_a[w_grant];
            r_add_b    <= w_b[w_grant] ^ {req_sub[w_grant], 31'd0};
            r_resp_id  <= w_grant;
            r_wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + CW'(1);
          if (w_lat_done) begin
            r_resp_data  <= add_result;
            r_resp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rr_ptr     <= (r_resp_id == IDW'(NREQ - 1)) ? '0 : r_resp_id + IDW'(1);
            r_op_count   <= r_op_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;
  assign resp_valid = r_resp_valid;
  assign op_count   = r_op_count;

endmodule
